bcd_multi_conv: RTL and testbench

- Parametrised multi-channel sequential binary-to-BCD converter. It replaces the fixed pair of single-channel converters that feed the LCD character display.
- Converts N_CH binary channels with one shared shift/add-3 (double-dabble) datapath, scheduled round-robin.
- Adds per-channel update strobes, leading-zero blank masks, overflow saturation, and free-run or triggered modes.
- Sits between the measurement/data sources and the LCD display module, in the sys_clk domain.

---
 rtl/bcd_multi_conv_pkg.sv | 50 +++++
 rtl/bcd_multi_conv_dabble_step.sv | 37 +++
 rtl/bcd_multi_conv.sv | 195 +++++++++++++++++++
 tb/tb_bcd_multi_conv.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_multi_conv_pkg.sv
// Shared definitions for the multi-channel binary-to-BCD converter.
// - state_e       : 2-bit FSM state encoding
// - clog2 / idx_width : widths for the channel index and bit counter
// - sat_bound     : 10^digits - 1, the largest value a channel can show
// - guard_digits  : extra accumulator digits so a DATA_W value never overflows
package bcd_multi_conv_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StLoad  = 2'd1,
    StShift = 2'd2,
    StDone  = 2'd3
  } state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    longint unsigned v;
    r = 0;
    v = 1;
    while (v < longint'(n)) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // At least one bit even for a single channel.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 1) ? 1 : clog2(n);
  endfunction

  function automatic logic [63:0] sat_bound(input int unsigned digits);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < int'(digits); i++) begin
      r = r * 64'd10;
    end
    return r - 64'd1;
  endfunction

  // ceil(w/3) decimal digits always cover 2^w - 1 since log10(2) < 1/3.
  function automatic int unsigned bin_digits(input int unsigned w);
    return (w + 2) / 3;
  endfunction

  function automatic int unsigned guard_digits(input int unsigned w, input int unsigned digits);
    return (bin_digits(w) > digits) ? bin_digits(w) - digits : 0;
  endfunction

endpackage

// File: rtl/bcd_multi_conv_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD digit >= 5, then shift
// {acc, sreg} left by one bit.
// Ports:
//   acc       - BCD accumulator (NUM_DIGITS digits)
//   sreg      - binary shift register
//   acc_next  - accumulator after add-3 and shift
//   sreg_next - shift register after shift (LSB filled with 0)
module bcd_dabble_step #(
  parameter int unsigned NUM_DIGITS = 5,
  parameter int unsigned SREG_W     = 16
) (
  input  logic [NUM_DIGITS*4-1:0] acc,
  input  logic [SREG_W-1:0]       sreg,
  output logic [NUM_DIGITS*4-1:0] acc_next,
  output logic [SREG_W-1:0]       sreg_next
);

  localparam int unsigned AccW = NUM_DIGITS * 4;

  logic [AccW-1:0] adj;
  // Carry out of the top digit; always 0 because the accumulator is sized
  // with enough guard digits for the full binary range.
  logic            unused_carry;

  always_comb begin
    adj = acc;
    for (int d = 0; d < int'(NUM_DIGITS); d++) begin
      if (acc[d*4 +: 4] >= 4'd5) begin
        adj[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
      end
    end
    unused_carry = adj[AccW-1];
    acc_next     = {adj[AccW-2:0], sreg[SREG_W-1]};
    sreg_next    = {sreg[SREG_W-2:0], 1'b0};
  end

endmodule

// File: rtl/bcd_multi_conv.sv
// Multi-channel sequential binary-to-BCD converter with one shared
// double-dabble datapath, scheduled round-robin over the channels.
// Ports:
//   sys_clk, sys_rst_n - clock, asynchronous active-low reset
//   ch_data   - packed binary inputs, channel k at [k*DATA_W +: DATA_W]
//   start     - sweep request (ignored when AUTO=1)
//   busy      - registered, high while a sweep is in progress
//   bcd_data  - packed BCD, channel k at [k*DIGITS*4 +: DIGITS*4], digit 0 = LSD
//   blank     - leading-zero mask per digit (digit 0 never blanked)
//   ovf       - channel value exceeded 10^DIGITS-1 (shown as all 9s)
//   bcd_valid - one-cycle strobe aligned with a channel's new outputs
module bcd_multi_conv
  import bcd_multi_conv_pkg::*;
#(
  parameter int unsigned N_CH   = 2,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DIGITS = 5,
  parameter int unsigned AUTO   = 1
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [N_CH*DATA_W-1:0]   ch_data,
  input  logic                     start,
  output logic                     busy,
  output logic [N_CH*DIGITS*4-1:0] bcd_data,
  output logic [N_CH*DIGITS-1:0]   blank,
  output logic [N_CH-1:0]          ovf,
  output logic [N_CH-1:0]          bcd_valid
);

  localparam int unsigned AccDig = DIGITS + guard_digits(DATA_W, DIGITS);
  localparam int unsigned AccW   = AccDig * 4;
  localparam int unsigned ChW    = idx_width(N_CH);
  localparam int unsigned CntW   = idx_width(DATA_W);
  localparam logic [63:0] SatMax = sat_bound(DIGITS);

  state_e              state_q, state_d;
  logic [ChW-1:0]      ch_q, ch_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [DATA_W-1:0]   sreg_q, sreg_d;
  logic [AccW-1:0]     acc_q, acc_d;
  logic                sat_q, sat_d;
  logic                busy_q;

  logic [N_CH*DIGITS*4-1:0] bcd_q, bcd_d;
  logic [N_CH*DIGITS-1:0]   blank_q, blank_d;
  logic [N_CH-1:0]          ovf_q, ovf_d;
  logic [N_CH-1:0]          valid_q, valid_d;

  logic [DATA_W-1:0]   snap;
  logic [AccW-1:0]     acc_step;
  logic [DATA_W-1:0]   sreg_step;
  logic [DIGITS*4-1:0] res_digits;
  logic [DIGITS-1:0]   res_blank;
  logic                zero_run;

  bcd_dabble_step #(
    .NUM_DIGITS(AccDig),
    .SREG_W    (DATA_W)
  ) u_step (
    .acc      (acc_q),
    .sreg     (sreg_q),
    .acc_next (acc_step),
    .sreg_next(sreg_step)
  );

  // Channel select mux for the snapshot.
  always_comb begin
    snap = '0;
    for (int k = 0; k < int'(N_CH); k++) begin
      if (ch_q == ChW'(k)) begin
        snap = ch_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // FSM and shared datapath next state.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    sreg_d  = sreg_q;
    acc_d   = acc_q;
    sat_d   = sat_q;

    // Requests during a sweep coalesce into a single follow-up sweep.
    if (AUTO == 0 && start && state_q != StIdle) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (AUTO != 0 || start || pend_q) begin
          state_d = StLoad;
          ch_d    = '0;
          pend_d  = 1'b0;
        end
      end
      StLoad: begin
        sreg_d  = snap;
        acc_d   = '0;
        sat_d   = ({{(64-DATA_W){1'b0}}, snap} > SatMax);
        cnt_d   = CntW'(DATA_W - 1);
        state_d = StShift;
      end
      StShift: begin
        acc_d  = acc_step;
        sreg_d = sreg_step;
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StDone: begin
        if (ch_q == ChW'(N_CH - 1)) begin
          ch_d    = '0;
          state_d = StIdle;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Result formatting for the channel finishing in DONE.
  always_comb begin
    res_digits = sat_q ? {DIGITS{4'h9}} : acc_q[DIGITS*4-1:0];
    res_blank  = '0;
    zero_run   = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_run     = zero_run & (acc_q[i*4 +: 4] == 4'd0);
      res_blank[i] = zero_run & ~sat_q;
    end
  end

  // Per-channel output registers; only DONE writes, so partial results never land.
  always_comb begin
    bcd_d   = bcd_q;
    blank_d = blank_q;
    ovf_d   = ovf_q;
    valid_d = '0;
    if (state_q == StDone) begin
      for (int k = 0; k < int'(N_CH); k++) begin
        if (ch_q == ChW'(k)) begin
          bcd_d[k*DIGITS*4 +: DIGITS*4] = res_digits;
          blank_d[k*DIGITS +: DIGITS]   = res_blank;
          ovf_d[k]                      = sat_q;
          valid_d[k]                    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= StIdle;
      ch_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      sreg_q  <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      busy_q  <= 1'b0;
      bcd_q   <= '0;
      blank_q <= '0;
      ovf_q   <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      sreg_q  <= sreg_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      busy_q  <= (state_d != StIdle);
      bcd_q   <= bcd_d;
      blank_q <= blank_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign busy      = busy_q;
  assign bcd_data  = bcd_q;
  assign blank     = blank_q;
  assign ovf       = ovf_q;
  assign bcd_valid = valid_q;

endmodule

// File: tb/tb_bcd_multi_conv.sv
module tb_bcd_multi_conv;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Main instance: AUTO=0, 2 channels, 16 bits, 5 digits.
  logic [31:0] m_data;
  logic        m_start, m_busy;
  logic [39:0] m_bcd;
  logic [9:0]  m_blank;
  logic [1:0]  m_ovf, m_valid;

  // Four-digit instance for saturation: AUTO=0, 1 channel.
  logic [15:0] f_data;
  logic        f_start, f_busy;
  logic [15:0] f_bcd;
  logic [3:0]  f_blank;
  logic [0:0]  f_ovf, f_valid;

  // Free-running instance: AUTO=1, 2 channels.
  logic [31:0] a_data;
  logic        a_start, a_busy;
  logic [39:0] a_bcd;
  logic [9:0]  a_blank;
  logic [1:0]  a_ovf, a_valid;

  bcd_multi_conv #(.N_CH(2), .DATA_W(16), .DIGITS(5), .AUTO(0)) u_dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .ch_data(m_data), .start(m_start), .busy(m_busy),
    .bcd_data(m_bcd), .blank(m_blank), .ovf(m_ovf), .bcd_valid(m_valid)
  );

  bcd_multi_conv #(.N_CH(1), .DATA_W(16), .DIGITS(4), .AUTO(0)) u_d4 (
    .sys_clk(clk), .sys_rst_n(rst_n), .ch_data(f_data), .start(f_start), .busy(f_busy),
    .bcd_data(f_bcd), .blank(f_blank), .ovf(f_ovf), .bcd_valid(f_valid)
  );

  bcd_multi_conv #(.N_CH(2), .DATA_W(16), .DIGITS(5), .AUTO(1)) u_auto (
    .sys_clk(clk), .sys_rst_n(rst_n), .ch_data(a_data), .start(a_start), .busy(a_busy),
    .bcd_data(a_bcd), .blank(a_blank), .ovf(a_ovf), .bcd_valid(a_valid)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int unsigned a;
    int unsigned b;
    logic [19:0] e0;
    logic [4:0]  bl0;
    logic [19:0] e1;
    logic [4:0]  bl1;
  } vec_t;

  vec_t tbl[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %0s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // Reference model: decimal digits by repeated division.
  function automatic logic [39:0] ref_bcd(input longint unsigned v, input int digits);
    logic [39:0] r;
    longint unsigned lim, x;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    r = '0;
    x = v;
    for (int d = 0; d < digits; d++) begin
      r[d*4 +: 4] = (v > lim - 1) ? 4'd9 : 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [9:0] ref_blank(input longint unsigned v, input int digits);
    logic [9:0] r;
    longint unsigned lim, x;
    int nd;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    r = '0;
    if (v > lim - 1) return r;
    nd = 1;
    x = v / 10;
    while (x > 0) begin
      nd++;
      x = x / 10;
    end
    for (int d = nd; d < digits; d++) r[d] = 1'b1;
    return r;
  endfunction

  // One sweep on u_dut starting with start accepted in cycle 0; optionally
  // extra start pulses at cycles 5 and 10 and ch0 changed at cycle 20.
  task automatic dut_sweep(input int unsigned a, input int unsigned b,
                           input logic [19:0] e0, input logic [4:0] bl0,
                           input logic [19:0] e1, input logic [4:0] bl1,
                           input bit extra, input int unsigned a2, input string tag);
    int last;
    logic [1:0] ev;
    logic eb;
    logic [39:0] t_bcd;
    logic [9:0]  t_bl;
    last = extra ? 85 : 40;
    t_bcd = ref_bcd(longint'(a2), 5);
    t_bl  = ref_blank(longint'(a2), 5);
    m_data  = {b[15:0], a[15:0]};
    m_start = 1'b1;
    for (int c = 1; c <= last; c++) begin
      tick();
      m_start = extra && (c == 5 || c == 10);
      if (extra && c == 20) m_data[15:0] = a2[15:0];
      eb = (c <= 36) || (extra && c >= 38 && c <= 73);
      ev = 2'b00;
      if (c == 19 || (extra && c == 56)) ev = 2'b01;
      if (c == 37 || (extra && c == 74)) ev = 2'b10;
      chk($sformatf("%0s busy c%0d", tag, c), 64'(m_busy), 64'(eb));
      chk($sformatf("%0s valid c%0d", tag, c), 64'(m_valid), 64'(ev));
      if (c == 19) begin
        chk($sformatf("%0s bcd0", tag), 64'(m_bcd[19:0]), 64'(e0));
        chk($sformatf("%0s blank0", tag), 64'(m_blank[4:0]), 64'(bl0));
        chk($sformatf("%0s ovf0", tag), 64'(m_ovf[0]), 64'd0);
      end
      if (c == 37) begin
        chk($sformatf("%0s bcd1", tag), 64'(m_bcd[39:20]), 64'(e1));
        chk($sformatf("%0s blank1", tag), 64'(m_blank[9:5]), 64'(bl1));
        chk($sformatf("%0s ovf1", tag), 64'(m_ovf[1]), 64'd0);
        chk($sformatf("%0s bcd0 held", tag), 64'(m_bcd[19:0]), 64'(e0));
      end
      if (extra && c == 56) begin
        chk($sformatf("%0s 2nd bcd0", tag), 64'(m_bcd[19:0]), 64'(t_bcd[19:0]));
        chk($sformatf("%0s 2nd blank0", tag), 64'(m_blank[4:0]), 64'(t_bl[4:0]));
      end
      if (extra && c == 74) begin
        chk($sformatf("%0s 2nd bcd1", tag), 64'(m_bcd[39:20]), 64'(e1));
      end
    end
  endtask

  task automatic d4_conv(input int unsigned v, input logic [15:0] eb, input logic [3:0] ebl,
                         input logic eo, input string tag);
    int got_c;
    got_c = -1;
    f_data  = v[15:0];
    f_start = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      tick();
      f_start = 1'b0;
      if (f_valid[0] && got_c < 0) begin
        got_c = c;
        chk($sformatf("%0s bcd", tag), 64'(f_bcd), 64'(eb));
        chk($sformatf("%0s blank", tag), 64'(f_blank), 64'(ebl));
        chk($sformatf("%0s ovf", tag), 64'(f_ovf), 64'(eo));
      end
    end
    chk($sformatf("%0s latency", tag), 64'(got_c), 64'd19);
  endtask

  task automatic wait_valid(input int idx, input int bound, output int n);
    bit seen;
    n = -1;
    seen = 1'b0;
    for (int c = 1; c <= bound; c++) begin
      if (!seen) begin
        tick();
        if (a_valid[idx]) begin
          n = c;
          seen = 1'b1;
        end
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " m"}, 64'({m_busy, m_bcd, m_blank, m_ovf, m_valid}), 64'd0);
    chk({tag, " f"}, 64'({f_busy, f_bcd, f_blank, f_ovf, f_valid}), 64'd0);
    chk({tag, " a"}, 64'({a_busy, a_bcd, a_blank, a_ovf, a_valid}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int unsigned ra, rb, rv;
    logic [39:0] t0, t1;
    logic [9:0]  b0, b1;
    logic [1:0]  first_v;

    rst_n   = 1'b0;
    m_start = 1'b0;
    f_start = 1'b0;
    a_start = 1'b0;
    m_data  = '0;
    f_data  = '0;
    a_data  = {16'd4242, 16'd100};

    tbl[0] = '{12345, 0,     20'h12345, 5'b00000, 20'h00000, 5'b11110};
    tbl[1] = '{65535, 9,     20'h65535, 5'b00000, 20'h00009, 5'b11110};
    tbl[2] = '{100,   1000,  20'h00100, 5'b11000, 20'h01000, 5'b10000};
    tbl[3] = '{7,     10,    20'h00007, 5'b11110, 20'h00010, 5'b11100};
    tbl[4] = '{40960, 5,     20'h40960, 5'b00000, 20'h00005, 5'b11110};

    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("idle without start", 64'(m_busy), 64'd0);
    end

    foreach (tbl[i]) begin
      dut_sweep(tbl[i].a, tbl[i].b, tbl[i].e0, tbl[i].bl0, tbl[i].e1, tbl[i].bl1,
                1'b0, 0, $sformatf("tbl%0d", i));
    end

    dut_sweep(111, 222, 20'h00111, 5'b11000, 20'h00222, 5'b11000, 1'b1, 4321, "pend");

    for (int i = 0; i < 5; i++) begin
      ra = $urandom_range(0, 65535);
      rb = $urandom_range(0, 65535);
      t0 = ref_bcd(longint'(ra), 5);
      t1 = ref_bcd(longint'(rb), 5);
      b0 = ref_blank(longint'(ra), 5);
      b1 = ref_blank(longint'(rb), 5);
      dut_sweep(ra, rb, t0[19:0], b0[4:0], t1[19:0], b1[4:0], 1'b0, 0,
                $sformatf("rnd%0d", i));
    end

    d4_conv(10000, 16'h9999, 4'b0000, 1'b1, "d4 10000");
    d4_conv(9999,  16'h9999, 4'b0000, 1'b0, "d4 9999");
    d4_conv(0,     16'h0000, 4'b1110, 1'b0, "d4 0");
    d4_conv(65535, 16'h9999, 4'b0000, 1'b1, "d4 65535");
    for (int i = 0; i < 4; i++) begin
      rv = $urandom_range(0, 20000);
      t0 = ref_bcd(longint'(rv), 4);
      b0 = ref_blank(longint'(rv), 4);
      d4_conv(rv, t0[15:0], b0[3:0], (rv > 9999), $sformatf("d4 rnd%0d", i));
    end

    // Free-running: change ch0 while its SHIFT is in progress.
    wait_valid(1, 80, n);
    chk("auto sync", 64'(n > 0), 64'd1);
    repeat (5) tick();
    a_data[15:0] = 16'd200;
    wait_valid(0, 40, n);
    chk("auto ch0 latency", 64'(n), 64'd14);
    chk("auto ch0 old value", 64'(a_bcd[19:0]), 64'(20'h00100));
    chk("auto ch0 blank", 64'(a_blank[4:0]), 64'(5'b11000));
    wait_valid(1, 40, n);
    chk("auto ch1 latency", 64'(n), 64'd18);
    chk("auto ch1 value", 64'(a_bcd[39:20]), 64'(20'h04242));
    chk("auto ch1 blank", 64'(a_blank[9:5]), 64'(5'b10000));
    wait_valid(0, 40, n);
    chk("auto sweep gap", 64'(n), 64'd19);
    chk("auto ch0 new value", 64'(a_bcd[19:0]), 64'(20'h00200));

    // Reset during SHIFT of ch1.
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async reset");
    repeat (3) begin
      tick();
      chk_all_zero("held reset");
    end
    rst_n = 1'b1;
    n = -1;
    first_v = 2'b00;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (n < 0) begin
        if (a_valid != 2'b00) begin
          n = c;
          first_v = a_valid;
        end else begin
          chk($sformatf("post reset bcd c%0d", c), 64'(a_bcd), 64'd0);
        end
      end
    end
    chk("post reset first channel", 64'(first_v), 64'(2'b01));
    chk("post reset latency", 64'(n), 64'd19);
    chk("post reset ch0 value", 64'(a_bcd[19:0]), 64'(20'h00200));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
